ext_data_memory: RTL and testbench

Line-granular backing store that serves the L1 data cache's external memory port. Sits directly downstream of the CPU top: consumes `ext_mem_addr`, `ext_mem_cs`, `ext_mem_we` and `ext_mem_data_o`, and returns `ext_mem_data_i` and `ext_mem_ack`. Each access moves one 256-bit cache line after a fixed, parameterised latency, giving the cache realistic miss and write-back penalties. Access counters let the bench check the cache's miss and write-back traffic.

---
 rtl/ext_data_memory.sv | 143 ++++++++++++++
 tb/tb_ext_data_memory.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_data_memory.sv
// ext_data_memory: line-granular (256-bit) backing store for the L1 data
// cache's external port. Each accepted request completes after a fixed
// LATENCY with a one-cycle ack; read and write completions are counted.
//
// state | meaning
// IDLE  | waiting for cs_i; request is captured on the accepting edge
// BUSY  | counting down the latency; request inputs are ignored
// ACK   | ack_o high for exactly one cycle, then back to IDLE
//
// Timing: accept at edge E0, commit (edge entering ACK) at E0+LATENCY,
// back to IDLE at E0+LATENCY+1. The wait counter is loaded with
// LATENCY-1 and the commit fires on the BUSY edge that finds it at zero,
// so LATENCY=1 still passes through one BUSY cycle.
module ext_data_memory #(
  parameter int LINES   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr_i,
  input  logic         cs_i,
  input  logic         we_i,
  input  logic [255:0] data_i,
  output logic [255:0] data_o,
  output logic         ack_o,
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [255:0]       wdata_q, wdata_d;
  logic [255:0]       data_o_q, data_o_d;
  logic               ack_q, ack_d;
  logic [31:0]        rd_cnt_q, rd_cnt_d;
  logic [31:0]        wr_cnt_q, wr_cnt_d;
  logic               mem_we;

  // Line storage; deliberately not reset, contents undefined until written.
  logic [255:0] mem [LINES];

  // Byte offset and address bits above the line index alias away.
  logic unused_addr;
  assign unused_addr = ^{addr_i[4:0], addr_i[31:5+IDX_W]};

  // Next-state, request capture and commit logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    data_o_d = data_o_q;
    ack_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_i) begin
          idx_d   = addr_i[5 +: IDX_W];
          we_d    = we_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (we_q) begin
            mem_we   = 1'b1;
            data_o_d = wdata_q;
            wr_cnt_d = wr_cnt_q + 32'd1;
          end else begin
            data_o_d = mem[idx_q];
            rd_cnt_d = rd_cnt_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control, request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      data_o_q <= '0;
      ack_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      data_o_q <= data_o_d;
      ack_q    <= ack_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Array write on the commit edge; mem_we is derived from state_q, which
  // sits in IDLE while reset is held, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign data_o = data_o_q;
  assign ack_o  = ack_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_ext_data_memory.sv
// Randomised bench for ext_data_memory with a line-array reference model.
module tb_ext_data_memory;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr = '0;
  logic         cs = 1'b0;
  logic         we = 1'b0;
  logic [255:0] wdata = '0;
  logic [255:0] data_o;
  logic         ack;
  logic [31:0]  rd_cnt, wr_cnt;

  logic [31:0]  addr1 = '0;
  logic         cs1 = 1'b0;
  logic         we1 = 1'b0;
  logic [255:0] wdata1 = '0;
  logic [255:0] data_o1;
  logic         ack1;
  logic [31:0]  rd_cnt1, wr_cnt1;

  ext_data_memory #(.LINES(512), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .cs_i(cs), .we_i(we),
    .data_i(wdata), .data_o(data_o), .ack_o(ack),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  ext_data_memory #(.LINES(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .addr_i(addr1), .cs_i(cs1), .we_i(we1),
    .data_i(wdata1), .data_o(data_o1), .ack_o(ack1),
    .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [255:0] ref_mem [512];
  bit           ref_valid [512];
  logic [31:0]  exp_rd = 0;
  logic [31:0]  exp_wr = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] line_addr(input int line);
    logic [31:0] a;
    a = $urandom;
    a[13:5] = line[8:0];
    return a;
  endfunction

  task automatic scramble();
    addr  = $urandom;
    we    = $urandom_range(0, 1);
    wdata = rand256();
  endtask

  // Called right after a negedge with the DUT idle; returns after a negedge
  // with the DUT idle again.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [255:0] d);
    int n;
    bit got;
    int idx;
    idx = int'(a[13:5]);
    cs = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    scramble();
    n = 0; got = 0;
    while (!got && n < LAT + 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack) got = 1;
      else scramble();
    end
    cs = 1'b0;
    check({tag, "_latency"}, 256'(n), 256'(LAT));
    if (w) begin
      ref_mem[idx] = d;
      ref_valid[idx] = 1;
      exp_wr++;
      check({tag, "_wdata_o"}, data_o, d);
    end else begin
      exp_rd++;
      if (ref_valid[idx]) check({tag, "_rdata"}, data_o, ref_mem[idx]);
    end
    check({tag, "_rd_cnt"}, 256'(rd_cnt), 256'(exp_rd));
    check({tag, "_wr_cnt"}, 256'(wr_cnt), 256'(exp_wr));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_pulse"}, 256'(ack), 256'(0));
  endtask

  logic [255:0] v3, v7, vd;
  int ack_edges [4];

  initial begin
    // Reset held with cs asserted.
    cs = 1'b1; addr = 32'h40; we = 1'b1; wdata = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ack", 256'(ack), 256'(0));
      check("rst_data", data_o, 256'(0));
      check("rst_cnts", 256'({rd_cnt, wr_cnt}), 256'(0));
    end
    rst = 1'b1;
    access("wr_a5", 1'b1, 32'h0000_0040, {32{8'hA5}});
    access("rd_a5", 1'b0, 32'h0000_0040, rand256());
    check("rd_a5_val", data_o, {32{8'hA5}});

    // Address aliasing onto line 1.
    access("alias_wr", 1'b1, 32'h0000_0020, 256'h1);
    access("alias_rd1", 1'b0, 32'h0000_4020, '0);
    check("alias_rd1_val", data_o, 256'h1);
    access("alias_rd2", 1'b0, 32'h0000_003F, '0);
    check("alias_rd2_val", data_o, 256'h1);

    // Random traffic over a small line set, with wild upper/offset bits.
    for (int i = 0; i < 30; i++) begin
      int line;
      line = $urandom_range(0, 15) * 31;
      access("rand", 1'($urandom_range(0, 1)), line_addr(line), rand256());
    end

    // Back-to-back reads with cs held high.
    begin
      int e, k;
      e = 0; k = 0;
      cs = 1'b1; we = 1'b0; addr = 32'h0000_0040;
      while (k < 4 && e < 4 * (LAT + 2) + 20) begin
        @(posedge clk);
        e++;
        @(negedge clk);
        if (ack) begin
          ack_edges[k] = e;
          exp_rd++;
          check("b2b_rd_cnt", 256'(rd_cnt), 256'(exp_rd));
          check("b2b_data", data_o, ref_mem[2]);
          k++;
        end
      end
      cs = 1'b0;
      check("b2b_count", 256'(k), 256'(4));
      for (int j = 1; j < 4; j++)
        check("b2b_spacing", 256'(ack_edges[j] - ack_edges[j-1]), 256'(LAT + 2));
      @(negedge clk);
    end

    // Reset mid-access: line 3 keeps its earlier value.
    v3 = rand256();
    access("pre3", 1'b1, line_addr(3), v3);
    cs = 1'b1; we = 1'b1; addr = 32'h0000_0060; wdata = 256'hFF;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    cs = 1'b0;
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_ack", 256'(ack), 256'(0));
      check("abort_cnts", 256'({rd_cnt, wr_cnt}), 256'(0));
    end
    rst = 1'b1;
    access("post3", 1'b0, 32'h0000_0060, '0);
    check("post3_val", data_o, v3);

    // Reset during ACK: ack drops at once, write is kept.
    v7 = rand256();
    cs = 1'b1; we = 1'b1; addr = line_addr(7); wdata = v7;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < LAT + 5 && !ack; i++) @(negedge clk);
    check("ackrst_seen", 256'(ack), 256'(1));
    ref_mem[7] = v7; ref_valid[7] = 1;
    rst = 1'b0;
    #1;
    check("ackrst_drop", 256'(ack), 256'(0));
    exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    rst = 1'b1;
    access("post7", 1'b0, line_addr(7), '0);
    check("post7_val", data_o, v7);

    // LATENCY=1 instance: ack on the edge after acceptance.
    vd = rand256();
    for (int pass = 0; pass < 2; pass++) begin
      int n;
      cs1 = 1'b1; we1 = (pass == 0); addr1 = 32'h0000_0040; wdata1 = vd;
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (!ack1 && n < 10) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      cs1 = 1'b0;
      check("l1_latency", 256'(n), 256'(1));
      check("l1_data", data_o1, vd);
      @(negedge clk);
      check("l1_ack_pulse", 256'(ack1), 256'(0));
    end
    check("l1_cnts", 256'({rd_cnt1, wr_cnt1}), 256'({32'd1, 32'd1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
